// File: rtl/frame_sched_pkg.sv
// Shared types and helpers for the frame update scheduler: FSM state encoding,
// client-count bound and one-hot/index arithmetic used by the slot picker.
package frame_sched_pkg;

  localparam int unsigned MAX_CLIENTS = 8;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

  // One-hot vector with the bit at idx set.
  function automatic logic [MAX_CLIENTS-1:0] onehotOf(input logic [IDX_W-1:0] idx);
    logic [MAX_CLIENTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Reduce a sum of two indices (each below n) modulo n.
  function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W:0] sum, input int unsigned n);
    logic [IDX_W:0] r;
    r = (32'(sum) >= n) ? sum - (IDX_W+1)'(n) : sum;
    return r[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Client-side update handshake: per-client request/done levels from the
// game-object logic and the scheduler's one-hot grant back to them.
interface frame_update_scheduler_if #(
  parameter int unsigned NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0] updateReq;
  logic [NUM_CLIENTS-1:0] updateDone;
  logic [NUM_CLIENTS-1:0] updateGrant;

  modport master (output updateReq, output updateDone, input updateGrant);
  modport slave  (input updateReq, input updateDone, output updateGrant);
endinterface

// File: rtl/frame_update_scheduler_pick.sv
// sched_pick: combinational find-first-set over the pending mask, searching
// upward from startIdx and wrapping modulo NUM_CLIENTS.
module sched_pick
  import frame_sched_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  logic [IDX_W-1:0]       startIdx,
  output logic [NUM_CLIENTS-1:0] onehot,
  output logic [IDX_W-1:0]       index,
  output logic                   anyValid
);

  logic [MAX_CLIENTS-1:0] pendExt;
  assign pendExt = MAX_CLIENTS'(pending);

  always_comb begin
    index    = '0;
    anyValid = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!anyValid &&
          pendExt[wrapIdx((IDX_W+1)'(startIdx) + (IDX_W+1)'(i), NUM_CLIENTS)]) begin
        anyValid = 1'b1;
        index    = wrapIdx((IDX_W+1)'(startIdx) + (IDX_W+1)'(i), NUM_CLIENTS);
      end
    end
  end

  assign onehot = anyValid ? NUM_CLIENTS'(onehotOf(index)) : '0;

endmodule

// File: rtl/frame_update_scheduler.sv
// Grants one exclusive per-frame update slot at a time during vertical blanking.
// FRAME_SCHED_ROUND_ROBIN_EN: rotate the first-in-line client every frame (else fixed priority).
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   pixelClock,
  input  logic                   resetN,
  input  logic                   vSyncStart,
  input  logic                   visibleArea,
  frame_update_scheduler_if.slave bus,
  output logic                   busy,
  output logic                   overrun,
  output logic [NUM_CLIENTS-1:0] timeoutErr,
  output logic [15:0]            frameCount
);

  localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  sched_state_t           state, stateNext;
  logic [NUM_CLIENTS-1:0] pending, pendingNext;
  logic [NUM_CLIENTS-1:0] grant, grantNext;
  logic [IDX_W-1:0]       grantIdx, grantIdxNext;
  logic [TIMER_W-1:0]     timer, timerNext;
  logic                   overrunNext;
  logic                   busyNext;
  logic [NUM_CLIENTS-1:0] timeoutErrNext;
  logic [15:0]            frameCountNext;

  logic [NUM_CLIENTS-1:0] pickOnehot;
  logic [IDX_W-1:0]       pickIdx;
  logic                   pickValid;
  logic [IDX_W-1:0]       pickStart;
  logic [MAX_CLIENTS-1:0] doneExt;
  logic                   doneHit;

  assign doneExt         = MAX_CLIENTS'(bus.updateDone);
  assign doneHit         = doneExt[grantIdx];
  assign bus.updateGrant = grant;

`ifdef FRAME_SCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rotPtr, rotPtrNext;

  // Pointer steps on every frame start so SCAN already sees the new value.
  always_comb begin
    rotPtrNext = rotPtr;
    if (vSyncStart) rotPtrNext = wrapIdx((IDX_W+1)'(rotPtr) + (IDX_W+1)'(1), NUM_CLIENTS);
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) rotPtr <= '0;
    else         rotPtr <= rotPtrNext;
  end

  assign pickStart = rotPtr;
`else
  assign pickStart = '0;
`endif

  sched_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
    .pending  (pending),
    .startIdx (pickStart),
    .onehot   (pickOnehot),
    .index    (pickIdx),
    .anyValid (pickValid)
  );

  // Next-state and registered-output values.
  always_comb begin
    stateNext      = state;
    pendingNext    = pending;
    grantNext      = grant;
    grantIdxNext   = grantIdx;
    timerNext      = timer;
    overrunNext    = 1'b0;
    timeoutErrNext = timeoutErr;
    frameCountNext = frameCount;

    case (state)
      IDLE: begin
        if (vSyncStart) begin
          pendingNext = bus.updateReq;
          stateNext   = SCAN;
        end
      end
      SCAN: begin
        if (pickValid) begin
          grantNext    = pickOnehot;
          grantIdxNext = pickIdx;
          timerNext    = '0;
          stateNext    = WAIT;
        end else begin
          frameCountNext = frameCount + 16'd1;
          stateNext      = IDLE;
        end
      end
      WAIT: begin
        if (doneHit) begin
          pendingNext = pending & ~grant;
          grantNext   = '0;
          stateNext   = SCAN;
        end else if (timer == TIMER_LAST) begin
          timeoutErrNext = timeoutErr | grant;
          pendingNext    = pending & ~grant;
          grantNext      = '0;
          stateNext      = SCAN;
        end else if (timer != '1) begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    // Spilling into the visible area, or a new frame arriving, kills the frame.
    if (state != IDLE && (visibleArea || vSyncStart)) begin
      grantNext      = '0;
      pendingNext    = '0;
      overrunNext    = 1'b1;
      timeoutErrNext = timeoutErr;
      frameCountNext = frameCount;
      stateNext      = IDLE;
      if (vSyncStart) begin
        pendingNext = bus.updateReq;
        stateNext   = SCAN;
      end
    end

    // Held one cycle past the return to IDLE so the frame's final counters are settled.
    busyNext = (stateNext != IDLE) || (state != IDLE);
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      grantIdx   <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      timeoutErr <= '0;
      frameCount <= '0;
    end else begin
      state      <= stateNext;
      pending    <= pendingNext;
      grant      <= grantNext;
      grantIdx   <= grantIdxNext;
      timer      <= timerNext;
      busy       <= busyNext;
      overrun    <= overrunNext;
      timeoutErr <= timeoutErrNext;
      frameCount <= frameCountNext;
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: table of per-frame vectors plus
// hand-written abort, timeout, empty-frame, reset and rotation sequences.
module tb_frame_update_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic        pixelClock = 1'b0;
  logic        resetN     = 1'b0;
  logic        vSyncStart = 1'b0;
  logic        visibleArea = 1'b0;
  logic        busy, overrun;
  logic [N-1:0] timeoutErr;
  logic [15:0] frameCount;

  frame_update_scheduler_if #(.NUM_CLIENTS(N)) bus ();

  frame_update_scheduler #(.NUM_CLIENTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .pixelClock  (pixelClock),
    .resetN      (resetN),
    .vSyncStart  (vSyncStart),
    .visibleArea (visibleArea),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun),
    .timeoutErr  (timeoutErr),
    .frameCount  (frameCount)
  );

  always #5 pixelClock = ~pixelClock;

  int checks = 0;
  int errors = 0;
  int overrunCnt = 0;
  int ptrModel = 0;
  logic [15:0] expFrames = 16'd0;

  always @(negedge pixelClock) if (overrun === 1'b1) overrunCnt++;

  typedef struct {
    logic [3:0] req;
    int         doneDelay;
    int         numGrants;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixelClock);
    #1;
  endtask

  function automatic int startIdx();
`ifdef FRAME_SCHED_ROUND_ROBIN_EN
    return ptrModel;
`else
    return 0;
`endif
  endfunction

  function automatic logic [3:0] pickModel(input logic [3:0] p, input int s);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (s + k) % 4;
      if (p[j]) return 4'(1 << j);
    end
    return 4'b0;
  endfunction

  task automatic pulseVsync(input logic [3:0] req);
    vSyncStart     = 1'b1;
    bus.updateReq  = req;
    ptrModel       = (ptrModel + 1) % 4;
    step();
    vSyncStart     = 1'b0;
    bus.updateReq  = ~req;
  endtask

  // One complete frame; every client finishes doneDelay cycles after its grant.
  task automatic runFrame(input logic [3:0] req, input int doneDelay, input int numGrants,
                          input bit chkFirst, input logic [3:0] firstExp);
    logic [3:0] pend;
    logic [3:0] exp;
    pend = req;
    pulseVsync(req);
    step();
    for (int k = 0; k < numGrants; k++) begin
      exp = pickModel(pend, startIdx());
      if (k == 0 && chkFirst) chk("first_grant", 32'(bus.updateGrant), 32'(firstExp));
      chk("grant", 32'(bus.updateGrant), 32'(exp));
      if (k == 0) chk("busy_in_frame", 32'(busy), 32'd1);
      for (int j = 0; j < doneDelay; j++) begin
        bus.updateDone = ~exp;
        step();
        chk("grant_held", 32'(bus.updateGrant), 32'(exp));
      end
      bus.updateDone = exp;
      step();
      bus.updateDone = 4'b0;
      chk("grant_drop", 32'(bus.updateGrant), 32'd0);
      step();
      pend = pend & ~exp;
    end
    expFrames = expFrames + 16'd1;
    chk("frame_count", 32'(frameCount), 32'(expFrames));
    chk("grant_after_frame", 32'(bus.updateGrant), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [3:0] e1, e2, pend;

    vecs[0] = '{req: 4'b1011, doneDelay: 3, numGrants: 3};
    vecs[1] = '{req: 4'b0001, doneDelay: 0, numGrants: 1};
    vecs[2] = '{req: 4'b1000, doneDelay: 1, numGrants: 1};
    vecs[3] = '{req: 4'b0110, doneDelay: 2, numGrants: 2};
    vecs[4] = '{req: 4'b1111, doneDelay: 0, numGrants: 4};

    bus.updateReq  = 4'b0;
    bus.updateDone = 4'b0;
    step();
    step();
    resetN = 1'b1;
    step();

    chk("rst_grant", 32'(bus.updateGrant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeoutErr), 32'd0);
    chk("rst_frames", 32'(frameCount), 32'd0);

    foreach (vecs[i]) runFrame(vecs[i].req, vecs[i].doneDelay, vecs[i].numGrants, 1'b0, 4'b0);
    chk("no_overrun_normal", 32'(overrunCnt), 32'd0);
    chk("no_timeout_normal", 32'(timeoutErr), 32'd0);

    // Empty frame: SCAN then back to IDLE.
    step();
    chk("empty_busy_before", 32'(busy), 32'd0);
    pulseVsync(4'b0000);
    chk("empty_busy_t1", 32'(busy), 32'd1);
    chk("empty_grant", 32'(bus.updateGrant), 32'd0);
    step();
    expFrames = expFrames + 16'd1;
    chk("empty_busy_t2", 32'(busy), 32'd1);
    chk("empty_frames", 32'(frameCount), 32'(expFrames));
    step();
    chk("empty_busy_t3", 32'(busy), 32'd0);

    // Timeout on first client, then done exactly on the timeout cycle for the second.
    pend = 4'b1010;
    pulseVsync(pend);
    step();
    e1 = pickModel(pend, startIdx());
    pend = pend & ~e1;
    e2 = pickModel(pend, startIdx());
    chk("to_grant1", 32'(bus.updateGrant), 32'(e1));
    for (int j = 0; j < 15; j++) step();
    chk("to_grant1_last", 32'(bus.updateGrant), 32'(e1));
    step();
    chk("to_grant1_drop", 32'(bus.updateGrant), 32'd0);
    chk("to_err", 32'(timeoutErr), 32'(e1));
    step();
    chk("to_grant2", 32'(bus.updateGrant), 32'(e2));
    for (int j = 0; j < 15; j++) step();
    bus.updateDone = e2;
    step();
    bus.updateDone = 4'b0;
    chk("to_done_wins_grant", 32'(bus.updateGrant), 32'd0);
    chk("to_done_wins_err", 32'(timeoutErr), 32'(e1));
    step();
    expFrames = expFrames + 16'd1;
    chk("to_frames", 32'(frameCount), 32'(expFrames));

    // Visible area while client 0 holds its slot; done in the same cycle loses.
    pulseVsync(4'b0001);
    step();
    chk("ab_grant", 32'(bus.updateGrant), 32'd1);
    step();
    visibleArea    = 1'b1;
    bus.updateDone = 4'b0001;
    step();
    visibleArea    = 1'b0;
    bus.updateDone = 4'b0;
    chk("ab_grant_drop", 32'(bus.updateGrant), 32'd0);
    chk("ab_overrun", 32'(overrun), 32'd1);
    step();
    chk("ab_overrun_pulse", 32'(overrun), 32'd0);
    step();
    step();
    chk("ab_frames", 32'(frameCount), 32'(expFrames));
    chk("ab_overrun_cnt", 32'(overrunCnt), 32'd1);
    chk("ab_grant_idle", 32'(bus.updateGrant), 32'd0);

    // New frame start while a slot is held: abort and re-latch.
    pend = 4'b0011;
    pulseVsync(pend);
    step();
    chk("rv_grant1", 32'(bus.updateGrant), 32'(pickModel(pend, startIdx())));
    pulseVsync(4'b0100);
    chk("rv_grant_drop", 32'(bus.updateGrant), 32'd0);
    chk("rv_overrun", 32'(overrun), 32'd1);
    step();
    chk("rv_grant_new", 32'(bus.updateGrant), 32'b0100);
    bus.updateDone = 4'b0100;
    step();
    bus.updateDone = 4'b0;
    step();
    expFrames = expFrames + 16'd1;
    chk("rv_frames", 32'(frameCount), 32'(expFrames));
    chk("rv_overrun_cnt", 32'(overrunCnt), 32'd2);

    // Asynchronous reset in the middle of a slot.
    pulseVsync(4'b0001);
    step();
    chk("rs_grant", 32'(bus.updateGrant), 32'd1);
    step();
    resetN = 1'b0;
    #1;
    chk("rs_grant_async", 32'(bus.updateGrant), 32'd0);
    chk("rs_busy_async", 32'(busy), 32'd0);
    chk("rs_timeout_async", 32'(timeoutErr), 32'd0);
    chk("rs_frames_async", 32'(frameCount), 32'd0);
    chk("rs_overrun_async", 32'(overrun), 32'd0);
    expFrames = 16'd0;
    ptrModel  = 0;
    step();
    resetN = 1'b1;
    bus.updateReq = 4'b1111;
    for (int j = 0; j < 4; j++) step();
    chk("rs_idle_busy", 32'(busy), 32'd0);
    chk("rs_idle_grant", 32'(bus.updateGrant), 32'd0);

    // Three full frames from a fresh pointer.
    for (int f = 0; f < 3; f++) begin
      logic [3:0] first;
`ifdef FRAME_SCHED_ROUND_ROBIN_EN
      first = (f == 0) ? 4'b0010 : (f == 1) ? 4'b0100 : 4'b1000;
`else
      first = 4'b0001;
`endif
      runFrame(4'b1111, 0, 4, 1'b1, first);
    end
    chk("final_overrun_cnt", 32'(overrunCnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
